multicycle_control: RTL and testbench



---
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over the shared
// memory/ALU datapath, with a ready handshake and a bounded memory wait.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE    = 6'b000000,
  parameter logic [5:0] OP_LW       = 6'b100011,
  parameter logic [5:0] OP_SW       = 6'b101011,
  parameter logic [5:0] OP_BEQ      = 6'b000100,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXECUTE  = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_op_q, illegal_op_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             mem_state;
  logic             timeout_hit;

  always_comb begin
    state_d       = S_FETCH;
    op_d          = op_q;
    cnt_d         = '0;
    illegal_op_d  = 1'b0;
    mem_timeout_d = mem_timeout_q;
    timeout_hit   = 1'b0;
    mem_state     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // The counter only survives while a memory state keeps waiting, so any
    // entry into a memory state starts from zero.
    if (mem_state && !mem_ready) begin
      if ((MEM_TIMEOUT > 0) && (cnt_q == CNT_W'(MEM_TIMEOUT)))
        timeout_hit = 1'b1;
      else
        cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d = Opcode;
        if ((Opcode == OP_LW) || (Opcode == OP_SW))
          state_d = S_MEM_ADDR;
        else if (Opcode == OP_RTYPE)
          state_d = S_EXECUTE;
        else if (Opcode == OP_BEQ)
          state_d = S_BRANCH;
        else begin
          state_d      = S_FETCH;
          illegal_op_d = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        if (op_q == OP_LW)
          state_d = S_MEM_RD;
        else if (op_q == OP_SW)
          state_d = S_MEM_WR;
        else
          state_d = S_FETCH;
      end
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXECUTE:  state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase

    if (timeout_hit) begin
      state_d       = S_FETCH;
      mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      op_q          <= '0;
      cnt_q         <= '0;
      illegal_op_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      illegal_op_q  <= illegal_op_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Control bundle is a decode of the current state; reset and the timeout
  // cycle suppress every enable.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    if (!rst && !timeout_hit) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:   ALUSrcB = 2'b11;
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        default: ;
      endcase
    end
  end

  assign state       = rst ? 4'd0 : state_q;
  assign illegal_op  = illegal_op_q & ~rst;
  assign mem_timeout = mem_timeout_q & ~rst;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction expected traces built
// from the state/output table, compared every cycle, plus literal spot checks.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       illegal_op, mem_timeout;

  multicycle_control dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ill;
    logic        to;
  } exp_t;

  exp_t        exp;
  logic        exp_vld = 1'b0;
  logic        ill_pend = 1'b0;
  logic        sticky = 1'b0;
  int          vectors = 0;
  int          fails = 0;
  int          cyc_no = 0;
  logic [21:0] got_v;

  assign got_v = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  illegal_op, mem_timeout};

  // Control bundle per state code, straight from the output table.
  function automatic logic [15:0] bund(input logic [3:0] st, input logic rdy);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0: begin mrd = 1'b1; srcb = 2'b01; pcw = rdy; irw = rdy; end
      4'd1: srcb = 2'b11;
      4'd2: begin srca = 1'b1; srcb = 2'b10; end
      4'd3: begin mrd = 1'b1; iord = 1'b1; end
      4'd4: begin m2r = 1'b1; rw = 1'b1; end
      4'd5: begin mwr = 1'b1; iord = 1'b1; end
      4'd6: begin srca = 1'b1; aop = 2'b10; end
      4'd7: begin rdst = 1'b1; rw = 1'b1; end
      4'd8: begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc};
  endfunction

  always @(negedge clk) begin
    cyc_no++;
    if (exp_vld) begin
      vectors++;
      if (got_v !== exp) begin
        fails++;
        $display("FAIL cycle_%0d got st=%0d ctl=%h ill=%b to=%b, want st=%0d ctl=%h ill=%b to=%b",
                 cyc_no, got_v[21:18], got_v[17:2], got_v[1], got_v[0],
                 exp.st, exp.ctl, exp.ill, exp.to);
      end
    end
  end

  task automatic pin(input string nm, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setc(input logic [3:0] st, input logic rdy);
    mem_ready = rdy;
    exp.st    = st;
    exp.ctl   = bund(st, rdy);
    exp.ill   = ill_pend;
    exp.to    = sticky;
    exp_vld   = 1'b1;
    ill_pend  = 1'b0;
  endtask

  task automatic cyc(input logic [3:0] st, input logic rdy);
    setc(st, rdy);
    tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; mem_ready = 1'b1;
    exp = '0; exp_vld = 1'b1;
    ill_pend = 1'b0; sticky = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  // Decode onward; Opcode is scrambled after decode to prove it was latched.
  task automatic run_body(input logic [5:0] op, input int mw);
    Opcode = op;
    cyc(4'd1, 1'b0);
    Opcode = (op == OP_LW) ? OP_SW : ((op == OP_SW) ? OP_LW : 6'h3f);
    if (op == OP_LW) begin
      cyc(4'd2, 1'b0);
      for (int i = 0; i < mw; i++) cyc(4'd3, 1'b0);
      cyc(4'd3, 1'b1);
      cyc(4'd4, 1'b0);
    end else if (op == OP_SW) begin
      cyc(4'd2, 1'b0);
      for (int i = 0; i < mw; i++) cyc(4'd5, 1'b0);
      cyc(4'd5, 1'b1);
    end else if (op == OP_RTYPE) begin
      cyc(4'd6, 1'b0);
      cyc(4'd7, 1'b0);
    end else if (op == OP_BEQ) begin
      cyc(4'd8, 1'b0);
    end else begin
      ill_pend = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cyc(4'd0, 1'b0);
    cyc(4'd0, 1'b1);
    run_body(op, mw);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; Opcode = OP_RTYPE;
    exp = '0; exp_vld = 1'b1;
    #8;
    pin("in_reset", {8'd0, state, PCWrite, MemRead, IRWrite, RegWrite}, 16'h0000);
    do_reset(2);

    setc(4'd0, 1'b1);
    #3 pin("rst_release", {9'd0, state, MemRead, IRWrite, PCWrite}, 16'h0007);
    tick();
    Opcode = OP_RTYPE;
    cyc(4'd1, 1'b0);
    Opcode = 6'h3f;
    setc(4'd6, 1'b0);
    #3 pin("exec_aluop", {10'd0, state, ALUOp}, 16'h001a);
    tick();
    cyc(4'd7, 1'b0);

    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 0, 0);

    cyc(4'd0, 1'b1);
    Opcode = OP_BEQ;
    cyc(4'd1, 1'b0);
    Opcode = 6'h3f;
    setc(4'd8, 1'b0);
    #3 pin("beq_ctl", {11'd0, PCWriteCond, PCSource, ALUOp}, 16'h0015);
    tick();

    run_instr(6'b110110, 0, 0);
    setc(4'd0, 1'b0);
    #3 pin("illegal_pulse", {12'd0, state, illegal_op}, 16'h0001);
    tick();
    run_instr(OP_RTYPE, 1, 0);

    // Fifteen waits then ready on the deadline cycle: completes normally.
    run_instr(OP_LW, 2, 15);

    cyc(4'd0, 1'b1);
    Opcode = OP_LW;
    cyc(4'd1, 1'b0);
    Opcode = 6'h3f;
    cyc(4'd2, 1'b0);
    do_reset(1);
    run_instr(OP_SW, 0, 2);

    // Store that never completes: deadline cycle drops all enables.
    cyc(4'd0, 1'b1);
    Opcode = OP_SW;
    cyc(4'd1, 1'b0);
    Opcode = 6'h3f;
    cyc(4'd2, 1'b0);
    for (int i = 0; i < 15; i++) cyc(4'd5, 1'b0);
    setc(4'd5, 1'b0);
    exp.ctl = '0;
    tick();
    sticky = 1'b1;
    setc(4'd0, 1'b1);
    #3 pin("timeout_flag", {11'd0, mem_timeout, state}, 16'h0010);
    tick();
    run_body(OP_RTYPE, 0);
    cyc(4'd0, 1'b0);
    cyc(4'd0, 1'b0);
    do_reset(1);
    setc(4'd0, 1'b1);
    #3 pin("timeout_cleared", {11'd0, mem_timeout, state}, 16'h0000);
    tick();
    run_body(OP_BEQ, 0);
    run_instr(OP_LW, 0, 0);

    exp_vld = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
